// File: rtl/alu_pkg.sv
// Shared types for the two-stage pipelined ALU: op encoding and the
// control fields that ride along with the operands through stage 1.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_SLL = 3'd1,
    OP_ROR = 3'd2,
    OP_SRA = 3'd3,
    OP_ADD = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_AND = 3'd7
  } op_e;

  typedef struct packed {
    logic cin;
    op_e  op;
    logic sign;
  } s1_ctrl_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for ROL, SLL, ROR and SRA; any other op
// passes the operand through unchanged.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] amt,
  input  op_e                op,
  output logic [WIDTH-1:0]   out
);

  logic [2*WIDTH-1:0] rol_wide;
  logic [2*WIDTH-1:0] ror_wide;

  // Rotates shift a doubled copy of the operand, so the wrapped bits come for free.
  always_comb begin
    rol_wide = {a, a} << amt;
    ror_wide = {a, a} >> amt;
    unique case (op)
      OP_ROL:  out = rol_wide[2*WIDTH-1:WIDTH];
      OP_SLL:  out = a << amt;
      OP_ROR:  out = ror_wide[WIDTH-1:0];
      OP_SRA:  out = $signed(a) >>> amt;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides: stage 1 registers
// the (optionally inverted) operands, stage 2 computes and registers the result.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ofl,
  output logic             cout,
  output logic             zero
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    s1_ctrl_t         ctrl;
  } s1_payload_t;

  s1_payload_t      s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH:0]   sum_wide;
  logic [WIDTH-1:0] res;
  logic             res_ofl;
  logic             res_cout;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (s1_adv) s1_valid <= in_valid;
  end

  // NOTE: the payload has no reset on purpose; s1_valid alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_q.a         <= invA ? ~a : a;
      s1_q.b         <= invB ? ~b : b;
      s1_q.ctrl.cin  <= cin;
      s1_q.ctrl.op   <= op_e'(op);
      s1_q.ctrl.sign <= sign;
    end
  end

  alu_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
    .a   (s1_q.a),
    .amt (s1_q.b[SHAMT_W-1:0]),
    .op  (s1_q.ctrl.op),
    .out (shift_res)
  );

  assign sum_wide = {1'b0, s1_q.a} + {1'b0, s1_q.b} + {{WIDTH{1'b0}}, s1_q.ctrl.cin};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res      = shift_res;
    res_ofl  = 1'b0;
    res_cout = 1'b0;
    unique case (s1_q.ctrl.op)
      OP_ADD: begin
        res      = sum_wide[WIDTH-1:0];
        res_cout = sum_wide[WIDTH];
        res_ofl  = s1_q.ctrl.sign
                 ? (s1_q.a[WIDTH-1] == s1_q.b[WIDTH-1]) && (sum_wide[WIDTH-1] != s1_q.a[WIDTH-1])
                 : sum_wide[WIDTH];
      end
      OP_OR:   res = s1_q.a | s1_q.b;
      OP_XOR:  res = s1_q.a ^ s1_q.b;
      OP_AND:  res = s1_q.a & s1_q.b;
      default: res = shift_res;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so both stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out      <= '0;
      ofl      <= 1'b0;
      cout     <= 1'b0;
      zero     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out  <= res;
        ofl  <= res_ofl;
        cout <= res_cout;
        zero <= (res == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: a scoreboard queue holds expected results
// pushed at acceptance and popped when the DUT hands a result over.
module tb_alu_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [2:0]   op;
  logic         inv_a;
  logic         inv_b;
  logic         sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         ofl;
  logic         cout;
  logic         zero;

  typedef struct {
    logic [W-1:0] out;
    logic         ofl;
    logic         cout;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .invA      (inv_a),
    .invB      (inv_b),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .ofl       (ofl),
    .cout      (cout),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] ai, bi,
                                 input logic ci, ia, ib, sg);
    exp_t         e;
    logic [W-1:0] ap;
    logic [W-1:0] bp;
    logic [W-1:0] r;
    logic [W:0]   s;
    int           amt;
    ap = ia ? ~ai : ai;
    bp = ib ? ~bi : bi;
    amt = int'(bp[3:0]);
    r = ap;
    e.ofl = 1'b0;
    e.cout = 1'b0;
    case (o)
      3'd0: for (int k = 0; k < amt; k++) r = {r[W-2:0], r[W-1]};
      3'd1: for (int k = 0; k < amt; k++) r = {r[W-2:0], 1'b0};
      3'd2: for (int k = 0; k < amt; k++) r = {r[0], r[W-1:1]};
      3'd3: for (int k = 0; k < amt; k++) r = {r[W-1], r[W-1:1]};
      3'd4: begin
        s = ap + bp + ci;
        r = s[W-1:0];
        e.cout = s[W];
        e.ofl = sg ? ((ap[W-1] == bp[W-1]) && (r[W-1] != ap[W-1])) : s[W];
      end
      3'd5: r = ap | bp;
      3'd6: r = ap ^ bp;
      default: r = ap & bp;
    endcase
    e.out = r;
    e.zero = (r == 0);
    return e;
  endfunction

  // Output-side scoreboard: every handed-over result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got out=%h ofl=%b cout=%b zero=%b, required no result",
                 out, ofl, cout, zero);
      end else begin
        mon_e = sb.pop_front();
        if ({out, ofl, cout, zero} !== {mon_e.out, mon_e.ofl, mon_e.cout, mon_e.zero}) begin
          n_bad++;
          $display("FAIL result: got out=%h ofl=%b cout=%b zero=%b, required out=%h ofl=%b cout=%b zero=%b",
                   out, ofl, cout, zero, mon_e.out, mon_e.ofl, mon_e.cout, mon_e.zero);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] ai, bi,
                       input logic ci, ia, ib, sg);
    bit done = 1'b0;
    op = o; a = ai; b = bi; cin = ci; inv_a = ia; inv_b = ib; sign = sg;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        sb.push_back(model(o, ai, bi, ci, ia, ib, sg));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: got in_ready=0 for 50 cycles, required acceptance");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (sb.size() != 0 || out_valid) begin
      n_bad++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = 3'd0; inv_a = 1'b0; inv_b = 1'b0; sign = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_ofl", ofl, 1'b0);
    check_bit("reset_cout", cout, 1'b0);
    check_bit("reset_zero", zero, 1'b0);
    n_cmp++;
    if (out !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_out: got %h, required 0000", out);
    end
  endtask

  // The result is registered on the edge after the accepting edge.
  task automatic test_latency();
    issue(3'd4, 16'h0123, 16'h0234, 1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("latency_after_accept", out_valid, 1'b0);
    @(posedge clk); #1;
    check_bit("latency_result_valid", out_valid, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back_shifts();
    issue(3'd0, 16'h00EA, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'd2, 16'h3E15, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'd3, 16'hFA7B, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'd1, 16'h0018, 16'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("b2b_valid_mid", out_valid, 1'b1);
    @(posedge clk); #1;
    check_bit("b2b_valid_last", out_valid, 1'b1);
    n_cmp++;
    if (out !== 16'h8000) begin
      n_bad++;
      $display("FAIL b2b_last_out: got %h, required 8000", out);
    end
    @(posedge clk); #1;
    check_bit("b2b_empty_after", out_valid, 1'b0);
    drain();
  endtask

  task automatic test_add_overflow();
    issue(3'd4, 16'd20000, 16'd20000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(3'd4, 16'd60000, 16'd60000, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'd4, 16'd30000, 16'd30000, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'd4, 16'h0123, 16'h0234, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(3'd4, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(3'd7, 16'h0123, 16'h0234, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'd5, 16'h0123, 16'h0234, 1'b0, 1'b0, 1'b0, 1'b0);
    fork
      issue(3'd6, 16'h0123, 16'h0234, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        check_bit("bp_in_ready_low", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
          check_bit("bp_valid_held", out_valid, 1'b1);
          n_cmp++;
          if (out !== 16'h0020) begin
            n_bad++;
            $display("FAIL bp_out_held: got %h, required 0020", out);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_zero_and_reset();
    issue(3'd4, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    out_ready = 1'b0;
    issue(3'd4, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'd4, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1; op = 3'd5; a = 16'h0055; b = 16'h0000;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_bit("midreset_out_valid", out_valid, 1'b0);
    check_bit("midreset_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_bit("midreset_no_result", out_valid, 1'b0);
    end
    issue(3'd4, 16'd10, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("post_reset_after_accept", out_valid, 1'b0);
    @(posedge clk); #1;
    check_bit("post_reset_result_valid", out_valid, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back_shifts();
    test_add_overflow();
    test_backpressure();
    test_zero_and_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1, "timeout");
  end

endmodule
